spart_io: RTL
=============

SPART_IO -- requirements
Module: spart_io

Interface
REQ-001 SHALL have parameter DEFAULT_DB, default 16'd325, meaning baud divisor loaded at reset (50 MHz clock, 9600 baud, x16 oversample).
REQ-002 SHALL have port clk, input, 1, system clock.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port iocs, input, 1, CPU I/O chip select for one cycle per access.
REQ-005 SHALL have port ior, input, 1, 1=read, 0=write; qualified by iocs.
REQ-006 SHALL have port ioaddr, input, 2, register select: 00 data, 01 status, 10 divisor low, 11 divisor high.
REQ-007 SHALL have port wdata, input, 8, CPU write data.
REQ-008 SHALL have port rdata, output, 8, registered read data.
REQ-009 SHALL have port rda, output, 1, receive data available.
REQ-010 SHALL have port tbr, output, 1, transmit buffer ready.
REQ-011 SHALL have port txd, output, 1, serial out, idle high.
REQ-012 SHALL have port rxd, input, 1, asynchronous serial in.

Function
REQ-013 SHALL generate a baud tick every max(divisor,1) cycles; a write to either divisor byte reloads the counter immediately.
REQ-014 SHALL, on write to 00 with tbr=1, latch wdata, drop tbr next cycle; the write is ignored when tbr=0.
REQ-015 SHALL run TX FSM IDLE->START->DATA->STOP->IDLE; START begins on the first tick after the latch; each bit is held 16 ticks; data LSB first; tbr returns to 1 on the cycle STOP ends.
REQ-016 SHALL pass rxd through a two-flop synchronizer before any use.
REQ-017 SHALL run RX FSM IDLE->START->DATA->STOP->IDLE; a synchronized high-to-low in IDLE enters START; sampling occurs at tick 8 of each 16-tick bit.
REQ-018 SHALL return RX to IDLE if the start-bit mid-sample is high (false start), with no flag change.
REQ-019 SHALL, when the stop-bit sample is 1, store the byte in the RX buffer and set rda; on stop=0, discard the byte and set ferr.
REQ-020 SHALL, when a byte completes while rda=1, overwrite the buffer, keep rda=1, and set ovr.
REQ-021 SHALL, on read of 00, return the RX buffer next cycle and clear rda, unless a new byte completes that same cycle (then rda stays 1 and the new byte is buffered).
REQ-022 SHALL, on read of 01, return {4'b0, ferr, ovr, tbr, rda} and clear ferr and ovr; a flag set in the same cycle wins.
REQ-023 SHALL, on read of 10 or 11, return the divisor low or high byte; rdata holds its value when no read occurs.
REQ-024 SHALL allow TX and RX to operate simultaneously and independently.

Reset
REQ-025 SHALL, while rst=1, force txd=1, tbr=1, rda=0, rdata=0, ferr=0, ovr=0, divisor=DEFAULT_DB, both FSMs IDLE, all counters 0.
REQ-026 SHALL abandon any frame in progress mid-operation on rst, without a partial byte or flag surviving.

Structure
REQ-027 SHALL take register address constants, status bit positions, and TX/RX state enums from shared package spart_pkg.
REQ-028 SHALL implement the tick generator as sub-module spart_baud_gen (clk, rst, divisor, reload -> tick).

Verification
REQ-029 SHALL cover: divisor=4, write 0xA5 -> txd low 64 cycles, then 1,0,1,0,0,1,0,1 at 64 cycles each, then high 64 cycles; tbr=0 throughout, 1 after.
REQ-030 SHALL cover: rxd driven with frame 0x3C at divisor 4 -> rda=1 after stop; read 00 -> rdata=0x3C, rda=0.
REQ-031 SHALL cover: two frames 0x11 then 0x22 with no read -> status read = 0x07 with ovr=1, then data read = 0x22; a second status read gives ovr=0.
REQ-032 SHALL cover: frame with stop bit 0 -> rda stays 0, status bit3=1; a 20-cycle low glitch on rxd -> no state change.
REQ-033 SHALL cover: write 0x55 then a second write 0x99 while busy -> only 0x55 transmitted; rst asserted mid-frame -> txd=1 and tbr=1 immediately.
REQ-034 SHALL cover: write divisor bytes 0x02,0x00 -> tick period 2 cycles; divisor 0 -> tick every cycle.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared definitions for the SPART serial port: register map, status layout,
// FSM state encodings and the status-byte packer.
package spart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DIV_LO = 2'b10;
    localparam logic [1:0] ADDR_DIV_HI = 2'b11;

    localparam int STAT_RDA  = 0;
    localparam int STAT_TBR  = 1;
    localparam int STAT_OVR  = 2;
    localparam int STAT_FERR = 3;

    // One bit lasts 16 ticks; the receiver samples on the 8th tick of a bit.
    localparam logic [3:0] TICK_LAST = 4'd15;
    localparam logic [3:0] TICK_MID  = 4'd7;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'b00,
        TX_START = 2'b01,
        TX_DATA  = 2'b10,
        TX_STOP  = 2'b11
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'b00,
        RX_START = 2'b01,
        RX_DATA  = 2'b10,
        RX_STOP  = 2'b11
    } rx_state_t;

    function automatic logic [7:0] status_byte(input logic ferr, input logic ovr,
                                               input logic tbr, input logic rda);
        logic [7:0] s;
        s            = 8'h00;
        s[STAT_FERR] = ferr;
        s[STAT_OVR]  = ovr;
        s[STAT_TBR]  = tbr;
        s[STAT_RDA]  = rda;
        return s;
    endfunction

endpackage

// File: rtl/spart_baud_gen.sv
// Baud tick generator: one-cycle tick every max(divisor,1) clocks, restarted
// whenever the divisor register is rewritten.
module spart_baud_gen
    import spart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] divisor,
    input  logic        reload,
    output logic        tick
);

    logic [15:0] cnt_r;
    logic [15:0] last_s;
    logic        tick_r;

    // Terminal count; a zero divisor behaves like one.
    always_comb begin
        if (divisor == 16'd0) begin
            last_s = 16'd0;
        end else begin
            last_s = divisor - 16'd1;
        end
    end

    // Free-running counter with registered tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= 16'd0;
            tick_r <= 1'b0;
        end else if (reload) begin
            cnt_r  <= 16'd0;
            tick_r <= 1'b0;
        end else if (cnt_r >= last_s) begin
            cnt_r  <= 16'd0;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + 16'd1;
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/spart_io.sv
// SPART: CPU-mapped UART with programmable baud divisor, one-byte TX buffer and
// one-byte RX buffer with overrun / framing-error flags.
module spart_io
    import spart_pkg::*;
#(
    parameter logic [15:0] DEFAULT_DB = 16'd325
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       ior,
    input  logic [1:0] ioaddr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    logic        wr_s, rd_s, reload_s, tick_s;
    logic [15:0] divisor_r;

    tx_state_t   tx_state_r, tx_state_s;
    logic [3:0]  tx_tick_r, tx_tick_s;
    logic [2:0]  tx_bit_r, tx_bit_s;
    logic [7:0]  tx_buf_r, tx_buf_s;
    logic        tbr_r, tbr_s, txd_r, txd_s, tx_load_s, tx_slot_end_s;

    rx_state_t   rx_state_r, rx_state_s;
    logic [3:0]  rx_tick_r, rx_tick_s;
    logic [2:0]  rx_bit_r, rx_bit_s;
    logic [7:0]  rx_shift_r, rx_shift_s, rx_buf_r, rx_buf_s;
    logic        rx_meta_r, rx_sync_r, rx_prev_r;
    logic        rx_mid_s, rx_end_s, byte_ok_s, byte_bad_s;
    logic        rda_r, rda_s, ovr_r, ovr_s, ferr_r, ferr_s;
    logic [7:0]  rdata_r, rdata_s;

    assign wr_s      = iocs & ~ior;
    assign rd_s      = iocs & ior;
    assign reload_s  = wr_s & ((ioaddr == ADDR_DIV_LO) | (ioaddr == ADDR_DIV_HI));
    assign tx_load_s = wr_s & (ioaddr == ADDR_DATA) & tbr_r;

    spart_baud_gen u_baud (
        .clk     (clk),
        .rst     (rst),
        .divisor (divisor_r),
        .reload  (reload_s),
        .tick    (tick_s)
    );

    // Divisor register, byte-writable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divisor_r <= DEFAULT_DB;
        end else if (wr_s && (ioaddr == ADDR_DIV_LO)) begin
            divisor_r[7:0] <= wdata;
        end else if (wr_s && (ioaddr == ADDR_DIV_HI)) begin
            divisor_r[15:8] <= wdata;
        end else begin
            divisor_r <= divisor_r;
        end
    end

    assign tx_slot_end_s = tick_s & (tx_tick_r == TICK_LAST);

    // Transmit next-state; txd is derived from the next state so it is registered.
    always_comb begin
        tx_state_s = tx_state_r;
        tx_bit_s   = tx_bit_r;
        tx_buf_s   = tx_buf_r;
        tbr_s      = tbr_r;
        txd_s      = 1'b1;
        if (tx_state_r == TX_IDLE) begin
            tx_tick_s = 4'd0;
        end else if (tick_s) begin
            tx_tick_s = tx_tick_r + 4'd1;
        end else begin
            tx_tick_s = tx_tick_r;
        end
        if (tx_load_s) begin
            tx_buf_s = wdata;
            tbr_s    = 1'b0;
        end else begin
            tx_buf_s = tx_buf_r;
        end
        case (tx_state_r)
            TX_IDLE: begin
                if (tick_s && !tbr_r) begin
                    tx_state_s = TX_START;
                end else begin
                    tx_state_s = TX_IDLE;
                end
            end
            TX_START: begin
                if (tx_slot_end_s) begin
                    tx_state_s = TX_DATA;
                    tx_bit_s   = 3'd0;
                end else begin
                    tx_state_s = TX_START;
                end
            end
            TX_DATA: begin
                if (tx_slot_end_s && (tx_bit_r == 3'd7)) begin
                    tx_state_s = TX_STOP;
                end else if (tx_slot_end_s) begin
                    tx_bit_s = tx_bit_r + 3'd1;
                end else begin
                    tx_state_s = TX_DATA;
                end
            end
            TX_STOP: begin
                if (tx_slot_end_s) begin
                    tx_state_s = TX_IDLE;
                    tbr_s      = 1'b1;
                end else begin
                    tx_state_s = TX_STOP;
                end
            end
            default: begin
                tx_state_s = TX_IDLE;
                tbr_s      = 1'b1;
            end
        endcase
        case (tx_state_s)
            TX_START: txd_s = 1'b0;
            TX_DATA:  txd_s = tx_buf_r[tx_bit_s];
            default:  txd_s = 1'b1;
        endcase
    end

    // Transmit state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_r <= TX_IDLE;
            tx_tick_r  <= 4'd0;
            tx_bit_r   <= 3'd0;
            tx_buf_r   <= 8'h00;
            tbr_r      <= 1'b1;
            txd_r      <= 1'b1;
        end else begin
            tx_state_r <= tx_state_s;
            tx_tick_r  <= tx_tick_s;
            tx_bit_r   <= tx_bit_s;
            tx_buf_r   <= tx_buf_s;
            tbr_r      <= tbr_s;
            txd_r      <= txd_s;
        end
    end

    // Two-flop synchronizer plus previous value for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rxd;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    assign rx_mid_s = tick_s & (rx_tick_r == TICK_MID);
    assign rx_end_s = tick_s & (rx_tick_r == TICK_LAST);

    // Receive next-state; the frame completes at the stop-bit mid-sample.
    always_comb begin
        rx_state_s = rx_state_r;
        rx_bit_s   = rx_bit_r;
        rx_shift_s = rx_shift_r;
        byte_ok_s  = 1'b0;
        byte_bad_s = 1'b0;
        if (rx_state_r == RX_IDLE) begin
            rx_tick_s = 4'd0;
        end else if (tick_s) begin
            rx_tick_s = rx_tick_r + 4'd1;
        end else begin
            rx_tick_s = rx_tick_r;
        end
        case (rx_state_r)
            RX_IDLE: begin
                if (rx_prev_r && !rx_sync_r) begin
                    rx_state_s = RX_START;
                end else begin
                    rx_state_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_mid_s && rx_sync_r) begin
                    rx_state_s = RX_IDLE;
                end else if (rx_end_s) begin
                    rx_state_s = RX_DATA;
                    rx_bit_s   = 3'd0;
                end else begin
                    rx_state_s = RX_START;
                end
            end
            RX_DATA: begin
                if (rx_mid_s) begin
                    rx_shift_s = {rx_sync_r, rx_shift_r[7:1]};
                end else if (rx_end_s && (rx_bit_r == 3'd7)) begin
                    rx_state_s = RX_STOP;
                end else if (rx_end_s) begin
                    rx_bit_s = rx_bit_r + 3'd1;
                end else begin
                    rx_state_s = RX_DATA;
                end
            end
            RX_STOP: begin
                if (rx_mid_s) begin
                    rx_state_s = RX_IDLE;
                    byte_ok_s  = rx_sync_r;
                    byte_bad_s = ~rx_sync_r;
                end else begin
                    rx_state_s = RX_STOP;
                end
            end
            default: rx_state_s = RX_IDLE;
        endcase
    end

    // Flag and read-data updates; a flag being set beats a clear-on-read.
    always_comb begin
        rx_buf_s = byte_ok_s ? rx_shift_r : rx_buf_r;
        if (byte_ok_s) begin
            rda_s = 1'b1;
        end else if (rd_s && (ioaddr == ADDR_DATA)) begin
            rda_s = 1'b0;
        end else begin
            rda_s = rda_r;
        end
        if (byte_ok_s && rda_r) begin
            ovr_s = 1'b1;
        end else if (rd_s && (ioaddr == ADDR_STATUS)) begin
            ovr_s = 1'b0;
        end else begin
            ovr_s = ovr_r;
        end
        if (byte_bad_s) begin
            ferr_s = 1'b1;
        end else if (rd_s && (ioaddr == ADDR_STATUS)) begin
            ferr_s = 1'b0;
        end else begin
            ferr_s = ferr_r;
        end
        if (rd_s) begin
            case (ioaddr)
                ADDR_DATA:   rdata_s = rx_buf_r;
                ADDR_STATUS: rdata_s = status_byte(ferr_r, ovr_r, tbr_r, rda_r);
                ADDR_DIV_LO: rdata_s = divisor_r[7:0];
                ADDR_DIV_HI: rdata_s = divisor_r[15:8];
                default:     rdata_s = 8'h00;
            endcase
        end else begin
            rdata_s = rdata_r;
        end
    end

    // Receive state, buffer, flags and read-data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_r <= RX_IDLE;
            rx_tick_r  <= 4'd0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
            rx_buf_r   <= 8'h00;
            rda_r      <= 1'b0;
            ovr_r      <= 1'b0;
            ferr_r     <= 1'b0;
            rdata_r    <= 8'h00;
        end else begin
            rx_state_r <= rx_state_s;
            rx_tick_r  <= rx_tick_s;
            rx_bit_r   <= rx_bit_s;
            rx_shift_r <= rx_shift_s;
            rx_buf_r   <= rx_buf_s;
            rda_r      <= rda_s;
            ovr_r      <= ovr_s;
            ferr_r     <= ferr_s;
            rdata_r    <= rdata_s;
        end
    end

    assign rdata = rdata_r;
    assign rda   = rda_r;
    assign tbr   = tbr_r;
    assign txd   = txd_r;

endmodule
